// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I constants for the memory stage and the load extension logic:
//   - OPC_LOAD / OPC_STORE major opcodes
//   - F3_* funct3 width selectors for loads and stores
//   - mem_state_e: data-memory handshake states
//   - is_misaligned(): natural-alignment check for a funct3/address pair
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GNT   = 2'd1,
        WAIT_RDATA = 2'd2
    } mem_state_e;

    // Halfwords must sit on an even address, words on a multiple of four.
    // Bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        is_misaligned = mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load-data formatter: selects the addressed byte/halfword lane
// from a 32-bit memory word and sign- or zero-extends it according to funct3.
// Ports:
//   i_rdata    [31:0] raw word returned by memory
//   i_addr_lo  [1:0]  byte offset of the access inside the word
//   i_funct3   [2:0]  load width / signedness
//   o_result   [31:0] extended writeback value
// ---------------------------------------------------------------------------
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_result = i_rdata;
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_result = {24'd0, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_HU:   o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// RV32I memory pipeline stage. Issues loads/stores on a req/gnt/rvalid data
// bus, stalls upstream while an access is outstanding and registers the
// writeback result for the next stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i, instr_i         live instruction from execute
//   alu_result_i, rs2_i      effective address / result, store data
//   stall_o                  combinational hold request to upstream
//   valid_o, instr_o         registered writeback instruction
//   wb_data_o, misalign_o    registered result (trap address when misaligned)
//   dmem_*_o                 data-memory request fields
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i  data-memory responses
// ---------------------------------------------------------------------------
module mem_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       rs2_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [31:0]       wb_data_o,
    output logic              misalign_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    mem_state_e  r_state;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_wb_data;
    logic        r_misalign;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [1:0]  w_addr_lo;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_access;
    logic        w_req;
    logic        w_stall;
    logic [31:0] w_load_data;

    assign w_opcode  = instr_i[6:0];
    assign w_funct3  = instr_i[14:12];
    assign w_addr_lo = alu_result_i[1:0];

    // Unsupported funct3 values under a load/store opcode fall through to
    // the plain pass-through path.
    assign w_is_load  = valid_i && (w_opcode == OPC_LOAD) &&
                        (w_funct3 == F3_B  || w_funct3 == F3_H || w_funct3 == F3_W ||
                         w_funct3 == F3_BU || w_funct3 == F3_HU);
    assign w_is_store = valid_i && (w_opcode == OPC_STORE) &&
                        (w_funct3 == F3_B || w_funct3 == F3_H || w_funct3 == F3_W);
    assign w_misalign = (w_is_load || w_is_store) && is_misaligned(w_funct3, w_addr_lo);
    assign w_access   = (w_is_load || w_is_store) && !w_misalign;

    // Request fields come straight from the (stall-held) inputs, so the
    // request stays identical across WAIT_GNT cycles without extra registers.
    assign dmem_we_o   = w_is_store;
    assign dmem_addr_o = {alu_result_i[ADDR_W-1:2], 2'b00};

    // funct3[1:0] encodes the access size for both signed and unsigned loads.
    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = rs2_i;
        case (w_funct3[1:0])
            2'b00: begin
                dmem_be_o    = 4'b0001 << w_addr_lo;
                dmem_wdata_o = {4{rs2_i[7:0]}};
            end
            2'b01: begin
                dmem_be_o    = w_addr_lo[1] ? 4'b1100 : 4'b0011;
                dmem_wdata_o = {2{rs2_i[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = rs2_i;
            end
        endcase
    end

    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            IDLE, WAIT_GNT: begin
                w_req   = w_access;
                // A granted store retires this cycle; everything else waits.
                w_stall = w_access && !(w_is_store && dmem_gnt_i);
            end
            WAIT_RDATA: begin
                w_req   = 1'b0;
                w_stall = !dmem_rvalid_i;
            end
            default: begin
                w_req   = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    assign dmem_req_o = w_req;
    assign stall_o    = w_stall;

    load_extend u_load_extend (
        .i_rdata   (dmem_rdata_i),
        .i_addr_lo (w_addr_lo),
        .i_funct3  (w_funct3),
        .o_result  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_instr    <= 32'd0;
            r_wb_data  <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                IDLE, WAIT_GNT: begin
                    if (w_req) begin
                        if (dmem_gnt_i && w_is_store) begin
                            r_state    <= IDLE;
                            r_valid    <= 1'b1;
                            r_instr    <= instr_i;
                            r_wb_data  <= 32'd0;
                            r_misalign <= 1'b0;
                        end else if (dmem_gnt_i) begin
                            r_state <= WAIT_RDATA;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= WAIT_GNT;
                            r_valid <= 1'b0;
                        end
                    end else begin
                        // Pass-through and misaligned traps both retire in
                        // one cycle; a trap reports the faulting address.
                        r_state    <= IDLE;
                        r_valid    <= valid_i;
                        if (valid_i) begin
                            r_instr    <= instr_i;
                            r_wb_data  <= alu_result_i;
                            r_misalign <= w_misalign;
                        end
                    end
                end
                WAIT_RDATA: begin
                    if (dmem_rvalid_i) begin
                        r_state    <= IDLE;
                        r_valid    <= 1'b1;
                        r_instr    <= instr_i;
                        r_wb_data  <= w_load_data;
                        r_misalign <= 1'b0;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o    = r_valid;
    assign instr_o    = r_instr;
    assign wb_data_o  = r_wb_data;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed scenarios with a hand-driven
// bus, then randomized traffic against a byte-addressed memory model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic [31:0] alu_result_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'd0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
        .alu_result_i(alu_result_i), .rs2_i(rs2_i), .stall_o(stall_o),
        .valid_o(valid_o), .instr_o(instr_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] wb;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        bus_manual = 1'b1;
    logic        exp_req = 1'b0;
    logic [31:0] bus_mem[16];
    logic [7:0]  ref_bytes[64];
    int          n_tx = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] mk(logic [6:0] opc, logic [2:0] f3);
        return {12'h0A5, 5'd2, f3, 5'd7, opc};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic v, logic [31:0] ins, logic [31:0] alu, logic [31:0] rs2);
        valid_i = v;
        instr_i = ins;
        alu_result_i = alu;
        rs2_i = rs2;
    endtask

    // Monitor: every retired result must match the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (!rst && valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid instr_o=%h wb_data_o=%h required=no output",
                         instr_o, wb_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("instr_o", instr_o, e.instr);
                chk("wb_data_o", wb_data_o, e.wb);
                chk("misalign_o", {31'd0, misalign_o}, {31'd0, e.mis});
                $display("retire instr=%h wb=%h mis=%0d", instr_o, wb_data_o, misalign_o);
            end
        end
    end

    // Randomized bus responder with a word memory written through byte enables.
    initial begin
        logic       rd_pending;
        int         rd_wait;
        int         gnt_wait;
        logic [3:0] rd_idx;
        rd_pending = 1'b0;
        rd_wait = 0;
        gnt_wait = 0;
        rd_idx = 4'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!bus_manual) begin
                dmem_gnt_i = 1'b0;
                dmem_rvalid_i = 1'b0;
                dmem_rdata_i = $urandom;
                chk("dmem_req_o", {31'd0, dmem_req_o}, {31'd0, exp_req && !rd_pending});
                if (rd_pending) begin
                    if (rd_wait == 0) begin
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i = bus_mem[rd_idx];
                        rd_pending = 1'b0;
                    end else begin
                        rd_wait--;
                    end
                end else if (dmem_req_o) begin
                    if (gnt_wait == 0) begin
                        dmem_gnt_i = 1'b1;
                        gnt_wait = $urandom_range(0, 2);
                        if (dmem_we_o) begin
                            for (int k = 0; k < 4; k++)
                                if (dmem_be_o[k])
                                    bus_mem[dmem_addr_o[5:2]][8*k +: 8] = dmem_wdata_o[8*k +: 8];
                        end else begin
                            rd_pending = 1'b1;
                            rd_idx = dmem_addr_o[5:2];
                            rd_wait = $urandom_range(0, 2);
                        end
                    end else begin
                        gnt_wait--;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    dmem_rvalid_i = 1'b1;  // spurious, must be ignored
                end
            end
        end
    end

    // One random instruction: reference result from byte-level memory rules.
    task automatic rand_tx();
        int          kind;
        int          size;
        int          off;
        int          base;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] r;
        logic [31:0] ins;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] val;
        logic        is_ld;
        logic        is_st;
        logic        mis;
        exp_t        e;
        int          n;
        kind = $urandom_range(0, 9);
        opc = (kind < 4) ? 7'b0000011 : (kind < 7) ? 7'b0100011 :
              (kind < 9) ? 7'b0110011 : 7'b1100011;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) f3 = r[2:0];
        else if (kind < 4) begin
            case ($urandom_range(0, 4))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
            endcase
        end else f3 = 3'($urandom_range(0, 2));
        is_ld = (opc == 7'b0000011) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_st = (opc == 7'b0100011) && (f3 inside {3'b000, 3'b001, 3'b010});
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = $urandom_range(0, 3);
        base = 4 * $urandom_range(0, 15);
        alu = (is_ld || is_st) ? 32'h1000 + base + off : $urandom;
        rs2 = $urandom;
        ins = {r[31:15], f3, r[11:7], opc};
        mis = (is_ld || is_st) && ((off % size) != 0);
        e.instr = ins;
        e.mis = 1'b0;
        if (mis) begin
            e.wb = alu;
            e.mis = 1'b1;
        end else if (is_st) begin
            for (int k = 0; k < size; k++) ref_bytes[base + off + k] = rs2[8*k +: 8];
            e.wb = 32'd0;
        end else if (is_ld) begin
            val = 32'd0;
            for (int k = 0; k < size; k++) val = val | (32'(ref_bytes[base + off + k]) << (8*k));
            if (f3[2] == 1'b0 && size < 4 && val[8*size-1]) val = val | (32'hFFFFFFFF << (8*size));
            e.wb = val;
        end else begin
            e.wb = alu;
        end
        cyc();
        drv(1'b1, ins, alu, rs2);
        exp_req = (is_ld || is_st) && !mis;
        sb.push_back(e);
        n_tx++;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (stall_o && n < 64);
        if (stall_o) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout actual=stalled 64 cycles required=completion");
        end
        if ($urandom_range(0, 3) == 0) begin
            cyc();
            drv(1'b0, 32'd0, 32'd0, 32'd0);
            exp_req = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=no finish required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        exp_t        e;
        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_instr_o", instr_o, 32'd0);
        chk("rst_wb_data_o", wb_data_o, 32'd0);
        chk("rst_stall_o", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        cyc();
        rst = 1'b0;

        // ---- zero-wait SW ----
        cyc();
        drv(1'b1, mk(7'b0100011, 3'b010), 32'h100, 32'hDEADBEEF);
        dmem_gnt_i = 1'b1;
        #1;
        chk("sw_req", {31'd0, dmem_req_o}, 32'd1);
        chk("sw_we", {31'd0, dmem_we_o}, 32'd1);
        chk("sw_be", {28'd0, dmem_be_o}, 32'hF);
        chk("sw_addr", dmem_addr_o, 32'h100);
        chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
        chk("sw_stall", {31'd0, stall_o}, 32'd0);
        e = '{instr: mk(7'b0100011, 3'b010), wb: 32'd0, mis: 1'b0};
        sb.push_back(e);

        // ---- SB at 0x103 ----
        cyc();
        drv(1'b1, mk(7'b0100011, 3'b000), 32'h103, 32'h000000A5);
        #1;
        chk("sb_be", {28'd0, dmem_be_o}, 32'h8);
        chk("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        chk("sb_addr", dmem_addr_o, 32'h100);
        e = '{instr: mk(7'b0100011, 3'b000), wb: 32'd0, mis: 1'b0};
        sb.push_back(e);

        // ---- LB at 0x202, grant delayed two cycles ----
        cyc();
        drv(1'b1, mk(7'b0000011, 3'b000), 32'h202, 32'd0);
        dmem_gnt_i = 1'b0;
        #1;
        chk("lb_req_c0", {31'd0, dmem_req_o}, 32'd1);
        chk("lb_stall_c0", {31'd0, stall_o}, 32'd1);
        cyc();
        chk("lb_stall_c1", {31'd0, stall_o}, 32'd1);
        cyc();
        dmem_gnt_i = 1'b1;
        #1;
        chk("lb_stall_c2", {31'd0, stall_o}, 32'd1);
        cyc();
        dmem_gnt_i = 1'b0;
        #1;
        chk("lb_req_wait", {31'd0, dmem_req_o}, 32'd0);
        chk("lb_stall_wait", {31'd0, stall_o}, 32'd1);
        cyc();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h12F45678;
        #1;
        chk("lb_stall_rvalid", {31'd0, stall_o}, 32'd0);
        e = '{instr: mk(7'b0000011, 3'b000), wb: 32'hFFFFFFF4, mis: 1'b0};
        sb.push_back(e);

        // ---- LBU at 0x202 ----
        cyc();
        dmem_rvalid_i = 1'b0;
        drv(1'b1, mk(7'b0000011, 3'b100), 32'h202, 32'd0);
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h12F45678;
        e = '{instr: mk(7'b0000011, 3'b100), wb: 32'h000000F4, mis: 1'b0};
        sb.push_back(e);

        // ---- LH at 0x206 (aligned, upper half) ----
        cyc();
        dmem_rvalid_i = 1'b0;
        drv(1'b1, mk(7'b0000011, 3'b001), 32'h206, 32'd0);
        dmem_gnt_i = 1'b1;
        #1;
        chk("lh_be", {28'd0, dmem_be_o}, 32'hC);
        chk("lh_req", {31'd0, dmem_req_o}, 32'd1);
        cyc();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h80001234;
        e = '{instr: mk(7'b0000011, 3'b001), wb: 32'hFFFF8000, mis: 1'b0};
        sb.push_back(e);

        // ---- LH at 0x201 (misaligned) ----
        cyc();
        dmem_rvalid_i = 1'b0;
        drv(1'b1, mk(7'b0000011, 3'b001), 32'h201, 32'd0);
        #1;
        chk("lhmis_req", {31'd0, dmem_req_o}, 32'd0);
        chk("lhmis_stall", {31'd0, stall_o}, 32'd0);
        e = '{instr: mk(7'b0000011, 3'b001), wb: 32'h201, mis: 1'b1};
        sb.push_back(e);

        // ---- ADD pass-through, then spurious rvalid while idle ----
        cyc();
        drv(1'b1, mk(7'b0110011, 3'b000), 32'd7, 32'd0);
        #1;
        chk("add_req", {31'd0, dmem_req_o}, 32'd0);
        chk("add_stall", {31'd0, stall_o}, 32'd0);
        e = '{instr: mk(7'b0110011, 3'b000), wb: 32'd7, mis: 1'b0};
        sb.push_back(e);
        cyc();
        drv(1'b0, 32'd0, 32'd0, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hCAFEF00D;
        cyc();
        dmem_rvalid_i = 1'b0;
        cyc();

        // ---- randomized traffic ----
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            bus_mem[i] = w;
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
        end
        bus_manual = 1'b0;
        for (int t = 0; t < 400; t++) rand_tx();
        cyc();
        drv(1'b0, 32'd0, 32'd0, 32'd0);
        exp_req = 1'b0;
        repeat (3) cyc();
        bus_manual = 1'b1;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        cyc();

        // ---- reset while waiting for load data ----
        drv(1'b1, mk(7'b0000011, 3'b010), 32'h300, 32'd0);
        dmem_gnt_i = 1'b1;
        #1;
        chk("rstld_req", {31'd0, dmem_req_o}, 32'd1);
        cyc();
        dmem_gnt_i = 1'b0;
        #1;
        chk("rstld_stall_wait", {31'd0, stall_o}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drv(1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        chk("rstld_stall_after", {31'd0, stall_o}, 32'd0);
        chk("rstld_valid_after", {31'd0, valid_o}, 32'd0);
        chk("rstld_wb_after", wb_data_o, 32'd0);
        cyc();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("rstld_stall_rvalid", {31'd0, stall_o}, 32'd0);
        cyc();
        dmem_rvalid_i = 1'b0;
        #1;
        chk("rstld_valid_ignored", {31'd0, valid_o}, 32'd0);
        chk("rstld_wb_ignored", wb_data_o, 32'd0);
        repeat (3) cyc();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("random transactions issued %0d", n_tx);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of execute: consumes the registered instr/ALU-result pair and performs RV32I loads/stores on the data-memory bus.
- Handles the req/gnt/rvalid handshake, byte-enable generation, store-data lane replication and load sign/zero extension.
- Stalls upstream while a memory access is outstanding; presents registered writeback data to the next stage.

Parameters:
- ADDR_W, 32, data-memory address width; the word address is alu_result_i[ADDR_W-1:0] with bits [1:0] forced to 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  instr_i/alu_result_i/rs2_i hold a live instruction
- instr_i  in  32  instruction from execute
- alu_result_i  in  32  effective address for loads/stores; result for all other instructions
- rs2_i  in  32  store data
- stall_o  out  1  combinational; upstream holds all inputs stable while it is 1
- valid_o  out  1  registered; instr_o/wb_data_o are valid
- instr_o  out  32  registered instruction
- wb_data_o  out  32  registered writeback data (trap address when misalign_o=1)
- misalign_o  out  1  registered misaligned-access flag
- dmem_req_o  out  1  request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  ADDR_W  word-aligned address
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  store data, replicated across lanes
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load data

Behaviour:
- Reset: state=IDLE; valid_o=0, instr_o=0, wb_data_o=0, misalign_o=0. dmem_req_o=0 and stall_o=0 combinationally while in IDLE with valid_i=0. Reset mid-access abandons it; a later rvalid is ignored.
- Decode: opcode 0000011 = load, 0100011 = store.
  - funct3 000 = B, 001 = H, 010 = W.
  - Load funct3 100 = BU, 101 = HU.
  - Any other funct3 is treated as a non-memory instruction.
- Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
  - No request is issued.
  - Next cycle: valid_o=1, misalign_o=1, wb_data_o=alu_result_i.
- Non-memory (valid_i=1): 1-cycle pass-through. valid_o<=1, instr_o<=instr_i, wb_data_o<=alu_result_i, misalign_o<=0. stall_o=0.
- Byte enables: B gives 1<<addr[1:0]; H gives 0011 or 1100 (selected by addr[1]); W gives 1111.
- Store data: wdata = {4{rs2[7:0]}} for B, {2{rs2[15:0]}} for H, rs2 for W.
- FSM states: IDLE, WAIT_GNT, WAIT_RDATA.
  - IDLE, valid aligned mem op: dmem_req_o=1 in the same cycle, with addr/we/be/wdata driven combinationally from the inputs.
    - Store with gnt: done. stall_o=0; valid_o<=1 next cycle, wb_data_o<=0.
    - Load with gnt: go to WAIT_RDATA, stall_o=1.
    - No gnt: go to WAIT_GNT, stall_o=1.
  - WAIT_GNT: request held with identical fields (inputs are held by the stall). On gnt, same outcomes as IDLE.
  - WAIT_RDATA: dmem_req_o=0, stall_o=1 until dmem_rvalid_i.
    - On rvalid: stall_o=0; wb_data_o<=extend(lane(rdata, addr[1:0])); valid_o<=1; go to IDLE.
    - rvalid and gnt in the same cycle are not possible for one access; the bus returns rvalid no earlier than the cycle after gnt.
- While stalled, valid_o<=0 (bubble each stalled cycle).
- dmem_rvalid_i outside WAIT_RDATA is ignored.
- Latency: 1 cycle for pass-through and zero-wait stores; loads take gnt cycle + rdata wait + 1.
- Downstream never back-pressures.

Decomposition:
- Shared riscv_pkg holds:
  - OPC_LOAD and OPC_STORE opcodes.
  - F3_B/H/W/BU/HU funct3 constants.
  - mem_state_e enum {IDLE, WAIT_GNT, WAIT_RDATA}.
  - Helper function for misalignment check.
- One sub-module: load_extend. It is combinational: rdata, addr[1:0], funct3 -> 32-bit sign/zero-extended result. It is reused by a future cache path.

Test Plan:
- Zero-wait SW: addr 0x100, rs2 0xDEADBEEF, gnt same cycle -> req=1, we=1, be=1111, addr=0x100, stall_o=0; next cycle valid_o=1.
- SB at addr 0x103, rs2 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, addr=0x100.
- LB at 0x202 with gnt delayed 2 cycles:
  - stall_o=1 for 3 cycles, then WAIT_RDATA.
  - rdata 0x12F45678 arrives after 1 further cycle -> wb_data_o=0xFFFFFFF4, valid_o=1.
  - Same access as LBU -> 0x000000F4.
- LH at 0x0206 -> misalign_o=0, be=1100. LH at 0x0201 -> no req; next cycle valid_o=1, misalign_o=1, wb_data_o=0x201.
- ADD (opcode 0110011) with alu_result 7 -> no req, stall_o=0; next cycle instr_o=instr, wb_data_o=7. Spurious dmem_rvalid_i in IDLE -> no effect.
- rst asserted in WAIT_RDATA:
  - Next cycle state=IDLE, valid_o=0, stall_o=0.
  - Subsequent rvalid with rdata 0xFFFFFFFF -> ignored, wb_data_o stays 0.
